fifo_dd_wr_arbiter: RTL and testbench
=====================================

// Module: fifo_dd_wr_arbiter
// PURPOSE
//  Shares the narrow write port of one sync_fifo_dd between NREQ producers. Grants
//  whole pairs of WI-bit words, so each 2*WI read word holds two words from one producer.
//  Round-robin between pairs. Throttles on FIFO level so a pair is never split by full.
//  Sits between the producers and the sync_fifo_dd write side; the read side is untouched.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  WI       8   write word width (same as the FIFO WI)
//  DEPTH    16  FIFO depth in WI words (same as the FIFO DEPTH)
//  LEVLBITS 5   FIFO level width; must hold 0..DEPTH
//  IDW      2   grant_id width; clog2(NREQ)
// PORTS
//  clk         in   1          clock, rising edge
//  reset_n     in   1          asynchronous reset, active low
//  enable      in   1          0: accept nothing; hold all state
//  clear       in   1          synchronous abort; drive to the FIFO clear at the same time
//  req         in   NREQ       req[k]=1: requester k presents a word on req_data slice k
//  req_data    in   NREQ*WI    slice k = bits [k*WI +: WI]
//  ack         out  NREQ       comb one-hot; the word is taken at this clock edge
//  fifo_wdata  out  WI         registered; goes to the FIFO wdata
//  fifo_write  out  1          registered; goes to the FIFO write
//  fifo_full   in   1          from the FIFO
//  fifo_level  in   LEVLBITS   from the FIFO; number of WI words stored
//  grant_id    out  IDW        registered; owner of the current or last pair
//  locked      out  1          registered; 1 between the first and second word of a pair
// BEHAVIOUR
//  Reset: fifo_write=0, fifo_wdata=0, grant_id=0, locked=0, rr pointer=0, ack=0.
//   A flop reset to 0 and set to 1 on the first clock gates ack, so ack is 0 while reset_n=0.
//  free = DEPTH - fifo_level - fifo_write. The registered write is not yet in the level.
//   Compute free at LEVLBITS+1 bits, unsigned; free is never negative.
//  State IDLE (locked=0):
//   - Requires enable=1, clear=0, fifo_full=0 and free>=2.
//   - Pick the first req[k] set, searching from rr_ptr upward and wrapping at NREQ.
//   - ack[k]=1. Next edge: fifo_write=1, fifo_wdata=slice k, grant_id=k, go to SECOND.
//  State SECOND (locked=1):
//   - Only requester grant_id may be acked; all other acks stay 0.
//   - If req[grant_id]=1 and enable=1: ack it, write its word.
//     Next edge: go to IDLE, rr_ptr = grant_id+1, wrapping NREQ-1 -> 0.
//   - If req[grant_id]=0: hold SECOND indefinitely. No other requester is served.
//   - Free space is always >=1 here, because 2 slots were reserved at pair start.
//  In any cycle with no ack, the next fifo_write=0 and fifo_wdata holds its value.
//  Latency: req high with space -> ack in the same cycle -> FIFO write on the next edge.
//   Peak rate is 1 word per clock.
//  Requester rule: hold req and data stable until ack. It may present the next word in the
//   cycle after ack.
//  enable=0: ack=0, the next fifo_write=0, state/rr_ptr/grant_id held, and an open pair
//   stays open.
//  clear=1 (wins over everything except reset):
//   - ack=0.
//   - Next edge: fifo_write=0, locked=0, state=IDLE, rr_ptr=0.
//   - A half pair is dropped. The FIFO is cleared at the same time.
//  Reset asserted mid-pair: all state returns to reset values asynchronously.
//  fifo_full=1 in IDLE: no new pair. It cannot occur in SECOND.
//  free==1 in IDLE: no new pair (prevents a split pair). Wait for a read.
// STRUCTURE
//  Shared header fifo_arb_defs.vh holds the state encodings ST_IDLE=1'b0, ST_SECOND=1'b1.
//  Sub-module rr_pick #(N): input req[N], input ptr[clog2 N]; output one-hot gnt, id, any.
//   Purely combinational rotate-priority search.
//  The top level holds the state flop, rr_ptr, the output registers, the free-space
//   compare and the ack mux.
// TESTING
//  Bench: instantiate with the real sync_fifo_dd (2*WI read port). Random reader gated on
//   empty. Per-requester scoreboards checked on each 2*WI read.
//  1 Single requester, NREQ=4:
//    - req[2] held with data 0x10,0x11,... -> ack[2] every cycle;
//      fifo_write every cycle from the next edge.
//    - Reads return 0x1110, 0x1312; grant_id=2 throughout.
//  2 All four requesting continuously ->
//    - Pairs are granted in order 0,0,1,1,2,2,3,3,0,0...
//    - Every read word has both bytes from the same requester.
//  3 Level 14, no reads, req[1]:
//    - One pair is written (level reaches 16, full).
//    - With level 15 and fifo_write=0, no first word is acked.
//    - After one read (level 14) a pair starts.
//  4 Requester 3 acked for its first word, then drops req for 5 cycles while req[0]=1 ->
//    - ack[0] stays 0 and locked=1.
//    - When req[3] returns, its second word is written, then requester 0 is granted.
//  5 clear pulse in SECOND ->
//    - The next edge gives locked=0, fifo_write=0 and rr_ptr=0.
//    - The FIFO is empty, and the next pair goes to the lowest active requester.
//  6 Sequence:
//    - enable=0 for 3 cycles mid-pair: no acks and no writes.
//    - enable=1 resumes the same owner's second word.
//    - reset_n pulsed low mid-pair: all outputs return to reset values at once.

Source files
------------

// File: rtl/fifo_dd_wr_arbiter_pkg.sv
// Shared types for the paired-word FIFO write arbiter.
// A pair is two consecutive narrow words from one producer.
package fifo_dd_wr_arbiter_pkg;

  typedef enum logic {
    StIdle   = 1'b0,
    StSecond = 1'b1
  } arb_state_e;

  // Slots that must be free before the first word of a pair is accepted.
  localparam int unsigned PairWords = 2;

endpackage

// File: rtl/fifo_dd_wr_arbiter_rr_pick.sv
// Rotate-priority search: first set request at or above ptr_i, wrapping at N.
// Purely combinational.
module fifo_dd_wr_arbiter_rr_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned IdW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IdW-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic [IdW-1:0] id_o,
  output logic           any_o
);

  always_comb begin
    int unsigned idx;
    idx   = 0;
    gnt_o = '0;
    id_o  = '0;
    any_o = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr_i) + i) % N;
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        id_o       = IdW'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_dd_wr_arbiter.sv
// Shares the narrow write port of a double-width-read FIFO between NREQ producers,
// granting whole pairs of words round-robin so no read word mixes two producers.
module fifo_dd_wr_arbiter
  import fifo_dd_wr_arbiter_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned WI       = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned LEVLBITS = 5,
  parameter int unsigned IDW      = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*WI-1:0]   req_data,
  output logic [NREQ-1:0]      ack,
  output logic [WI-1:0]        fifo_wdata,
  output logic                 fifo_write,
  input  logic                 fifo_full,
  input  logic [LEVLBITS-1:0]  fifo_level,
  output logic [IDW-1:0]       grant_id,
  output logic                 locked
);

  localparam int unsigned FW = LEVLBITS + 1;

  arb_state_e      state_q, state_d;
  logic            armed_q;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  grant_id_q, grant_id_d;
  logic            write_q, write_d;
  logic [WI-1:0]   wdata_q, wdata_d;
  logic [NREQ-1:0] pick_gnt;
  logic [IDW-1:0]  pick_id, sel_id;
  logic            pick_any;
  logic [FW-1:0]   free;
  logic            room, go;

  fifo_dd_wr_arbiter_rr_pick #(
    .N   (NREQ),
    .IdW (IDW)
  ) u_rr_pick (
    .req_i (req),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .id_o  (pick_id),
    .any_o (pick_any)
  );

  // The registered write has not reached the FIFO level yet, so count it here.
  assign free   = FW'(DEPTH) - {1'b0, fifo_level} - FW'(write_q);
  assign room   = !fifo_full && (free >= FW'(PairWords));
  assign go     = armed_q && enable && !clear;
  assign sel_id = (state_q == StSecond) ? grant_id_q : pick_id;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    write_d    = 1'b0;
    wdata_d    = wdata_q;
    if (clear) begin
      state_d  = StIdle;
      rr_ptr_d = '0;
    end else if (|ack) begin
      write_d = 1'b1;
      wdata_d = req_data[sel_id*WI +: WI];
      if (state_q == StIdle) begin
        state_d    = StSecond;
        grant_id_d = pick_id;
      end else begin
        state_d  = StIdle;
        rr_ptr_d = (grant_id_q == IDW'(NREQ - 1)) ? '0 : grant_id_q + 1'b1;
      end
    end
  end

  always_comb begin
    ack = '0;
    if (go) begin
      case (state_q)
        StIdle:   if (room && pick_any) ack = pick_gnt;
        StSecond: ack[grant_id_q] = req[grant_id_q];
        default:  ack = '0;
      endcase
    end
  end

  // armed_q keeps ack low until the first clock after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed_q    <= 1'b0;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
    end else begin
      armed_q    <= 1'b1;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
    end
  end

  assign fifo_write = write_q;
  assign fifo_wdata = wdata_q;
  assign grant_id   = grant_id_q;
  assign locked     = (state_q == StSecond);

endmodule

// File: tb/tb_fifo_dd_wr_arbiter.sv
// Bench for fifo_dd_wr_arbiter: a queue-based FIFO with a 2-word read port, a pair-level
// arbiter model checked every cycle, and directed scenarios with literal expectations.
module tb_fifo_dd_wr_arbiter;

  localparam int NREQ = 4, WI = 8, DEPTH = 16, LEVLBITS = 5, IDW = 2;

  logic                clk = 1'b0, reset_n = 1'b0, enable = 1'b0, clear = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*WI-1:0]  req_data = '0;
  logic [NREQ-1:0]     ack;
  logic [WI-1:0]       fifo_wdata;
  logic                fifo_write;
  logic                fifo_full = 1'b0;
  logic [LEVLBITS-1:0] fifo_level = '0;
  logic [IDW-1:0]      grant_id;
  logic                locked;

  int checks = 0, errors = 0;

  fifo_dd_wr_arbiter #(
    .NREQ (NREQ), .WI (WI), .DEPTH (DEPTH), .LEVLBITS (LEVLBITS), .IDW (IDW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .clear      (clear),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .fifo_wdata (fifo_wdata),
    .fifo_write (fifo_write),
    .fifo_full  (fifo_full),
    .fifo_level (fifo_level),
    .grant_id   (grant_id),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arbiter model: pair owner, whether a pair is half done, round-robin start point.
  bit              m_armed = 0, m_locked = 0, m_write = 0;
  int              m_gid = 0, m_rr = 0;
  logic [WI-1:0]   m_wdata = '0;
  logic [NREQ-1:0] exp_ack = '0, ack_s = '0;
  bit              fw_s = 0, mw_s = 0;
  logic [WI-1:0]   fwd_s = '0, mwd_s = '0;
  int              mg_s = 0;

  always @(negedge clk) begin
    int  room;
    bit  found;
    exp_ack = '0;
    if (reset_n && m_armed && enable && !clear) begin
      if (m_locked) begin
        exp_ack[m_gid] = req[m_gid];
      end else begin
        room = DEPTH - int'(fifo_level) - int'(m_write);
        found = 0;
        if (!fifo_full && room >= 2) begin
          for (int j = 0; j < NREQ; j++) begin
            int k;
            k = (m_rr + j) % NREQ;
            if (!found && req[k]) begin
              exp_ack[k] = 1'b1;
              found = 1;
            end
          end
        end
      end
    end
    ack_s = ack;
    fw_s  = fifo_write;
    fwd_s = fifo_wdata;
    mw_s  = m_write;
    mwd_s = m_wdata;
    mg_s  = m_gid;
    chk("ack", ack, exp_ack);
    chk("fifo_write", fifo_write, m_write);
    chk("fifo_wdata", fifo_wdata, m_wdata);
    chk("grant_id", grant_id, m_gid);
    chk("locked", locked, m_locked);
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_armed <= 0; m_locked <= 0; m_gid <= 0; m_rr <= 0; m_write <= 0; m_wdata <= '0;
    end else begin
      m_armed <= 1;
      if (clear) begin
        m_write <= 0; m_locked <= 0; m_rr <= 0;
      end else if (exp_ack != '0) begin
        int k;
        k = 0;
        for (int j = 0; j < NREQ; j++) if (exp_ack[j]) k = j;
        m_write <= 1;
        m_wdata <= req_data[k*WI +: WI];
        if (m_locked) begin
          m_locked <= 0;
          m_rr     <= (m_gid + 1) % NREQ;
        end else begin
          m_locked <= 1;
          m_gid    <= k;
        end
      end else begin
        m_write <= 0;
      end
    end
  end

  // FIFO model: WI-bit writes, 2*WI reads {second, first}; expected owner/data kept alongside.
  logic [WI-1:0]  fq[$];
  logic [WI-1:0]  ed[$];
  int             eo[$];
  logic [15:0]    rd_log[$];
  int             rd_credits = 0, preload = 0;
  bit             rd_free = 0, rd_rand = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fq.delete(); ed.delete(); eo.delete();
      fifo_level <= '0;
      fifo_full  <= 1'b0;
    end else begin
      if (clear) begin
        fq.delete(); ed.delete(); eo.delete();
      end else begin
        if (fq.size() >= 2 && (rd_free || rd_credits > 0) &&
            (!rd_rand || $urandom_range(0, 1) == 1)) begin
          logic [WI-1:0] b0, b1, e0, e1;
          int o0, o1;
          b0 = fq.pop_front();
          b1 = fq.pop_front();
          e0 = '0; e1 = '0; o0 = -1; o1 = -2;
          if (ed.size() >= 2) begin
            e0 = ed.pop_front(); e1 = ed.pop_front();
            o0 = eo.pop_front(); o1 = eo.pop_front();
          end
          rd_log.push_back({b1, b0});
          if (rd_credits > 0) rd_credits--;
          chk("rd_word", {b1, b0}, {e1, e0});
          if (o0 != 99 && o1 != 99) chk("pair_owner", o1, o0);
        end
        if (preload > 0) begin
          fq.push_back(8'hEE); ed.push_back(8'hEE); eo.push_back(99);
          preload--;
        end
        if (fw_s) fq.push_back(fwd_s);
        if (mw_s) begin
          ed.push_back(mwd_s); eo.push_back(mg_s);
        end
        chk("no_overflow", fq.size() > DEPTH, 0);
      end
      fifo_level <= LEVLBITS'(fq.size());
      fifo_full  <= (fq.size() == DEPTH);
    end
  end

  // Producers: src_left -1 = endless, else words still to offer; data increments per ack.
  int            src_left[NREQ];
  logic [WI-1:0] src_data[NREQ];
  int            ack_ids[$];

  task automatic cyc();
    @(posedge clk);
    for (int k = 0; k < NREQ; k++) begin
      if (ack_s[k]) begin
        if (src_left[k] > 0) src_left[k]--;
        src_data[k]++;
        ack_ids.push_back(k);
      end
    end
    #1;
    for (int k = 0; k < NREQ; k++) begin
      req[k] = (src_left[k] != 0);
      req_data[k*WI +: WI] = src_data[k];
    end
  endtask

  task automatic stop_all();
    for (int k = 0; k < NREQ; k++) src_left[k] = 0;
  endtask

  task automatic do_clear();
    stop_all();
    cyc(); cyc();
    clear = 1'b1;
    cyc();
    #2;
    chk("clear_locked", locked, 0);
    chk("clear_write", fifo_write, 0);
    clear = 1'b0;
    cyc();
  endtask

  task automatic wait_locked(input int want);
    int n;
    n = 0;
    while (!(locked && (want < 0 || int'(grant_id) == want)) && n < 40) begin
      cyc();
      n++;
    end
    chk("wait_locked_timeout", n < 40, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int ord[10];
    ord = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    for (int k = 0; k < NREQ; k++) begin
      src_left[k] = 0;
      src_data[k] = '0;
    end
    repeat (3) cyc();
    #2;
    chk("rst_ack", ack, 0);
    chk("rst_write", fifo_write, 0);
    chk("rst_wdata", fifo_wdata, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_locked", locked, 0);
    reset_n = 1'b1;
    enable  = 1'b1;
    cyc();

    // Single requester at full rate.
    rd_free = 1;
    rd_log.delete();
    src_left[2] = -1; src_data[2] = 8'h10;
    cyc();
    #2 chk("t1_ack_same_cycle", ack, 4'b0100);
    repeat (8) cyc();
    #2;
    chk("t1_write", fifo_write, 1);
    chk("t1_grant", grant_id, 2);
    chk("t1_rd0", rd_log[0], 16'h1110);
    chk("t1_rd1", rd_log[1], 16'h1312);
    do_clear();

    // All four requesting: pairs round-robin.
    rd_rand = 1;
    ack_ids.delete();
    for (int k = 0; k < NREQ; k++) begin
      src_left[k] = -1;
      src_data[k] = 8'(k * 64);
    end
    repeat (40) cyc();
    chk("t2_ack_count", ack_ids.size() >= 10, 1);
    for (int i = 0; i < 10; i++) chk("t2_order", ack_ids[i], ord[i]);
    stop_all();
    rd_rand = 0;
    repeat (20) cyc();
    do_clear();

    // Level 14: exactly one pair fits.
    rd_free = 0;
    preload = 14;
    repeat (16) cyc();
    #2 chk("t3_level14", fifo_level, 14);
    src_left[1] = -1; src_data[1] = 8'h50;
    repeat (6) cyc();
    #2;
    chk("t3_level16", fifo_level, 16);
    chk("t3_full", fifo_full, 1);
    chk("t3_no_ack_full", ack, 0);
    rd_credits = 1;
    repeat (5) cyc();
    #2 chk("t3_refill16", fifo_level, 16);
    do_clear();
    // Level 15: a lone free slot must not start a pair.
    preload = 15;
    repeat (17) cyc();
    src_left[1] = -1;
    repeat (4) cyc();
    #2;
    chk("t3_l15_ack", ack, 0);
    chk("t3_l15_write", fifo_write, 0);
    chk("t3_l15_level", fifo_level, 15);
    rd_credits = 1;
    repeat (6) cyc();
    #2 chk("t3_l15_after", fifo_level, 15);
    do_clear();

    // Owner drops req mid-pair; nobody else may be served.
    rd_free = 1;
    src_left[3] = 1; src_data[3] = 8'hA0;
    cyc();
    wait_locked(3);
    src_left[0] = -1; src_data[0] = 8'h30;
    for (int i = 0; i < 5; i++) begin
      cyc();
      #2;
      chk("t4_hold_ack", ack, 0);
      chk("t4_hold_locked", locked, 1);
    end
    src_left[3] = 1;
    cyc();
    #2 chk("t4_second", ack, 4'b1000);
    cyc();
    #2;
    chk("t4_next_owner", ack, 4'b0001);
    chk("t4_a1_written", fifo_wdata, 8'hA1);
    do_clear();

    // Clear in SECOND resets the round-robin pointer.
    for (int k = 0; k < NREQ; k++) src_left[k] = -1;
    wait_locked(1);
    clear = 1'b1;
    cyc();
    #2;
    chk("t5_locked", locked, 0);
    chk("t5_write", fifo_write, 0);
    chk("t5_level", fifo_level, 0);
    clear = 1'b0;
    cyc();
    #2;
    chk("t5_lowest", ack, 4'b0001);
    chk("t5_grant", grant_id, 0);
    do_clear();

    // enable low mid-pair, then an asynchronous reset mid-pair.
    src_left[2] = -1; src_data[2] = 8'h70;
    cyc();
    wait_locked(2);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      #2;
      chk("t6_dis_ack", ack, 0);
      chk("t6_dis_write", fifo_write, 0);
      chk("t6_dis_locked", locked, 1);
    end
    enable = 1'b1;
    #1 chk("t6_resume", ack, 4'b0100);
    cyc();
    cyc();
    wait_locked(2);
    #1 reset_n = 1'b0;
    #1;
    chk("t6_rst_ack", ack, 0);
    chk("t6_rst_write", fifo_write, 0);
    chk("t6_rst_wdata", fifo_wdata, 0);
    chk("t6_rst_grant", grant_id, 0);
    chk("t6_rst_locked", locked, 0);
    stop_all();
    cyc();
    reset_n = 1'b1;
    repeat (4) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
